// File: rtl/slave_port_arbiter_pkg.sv
// rtl/slave_port_arbiter_pkg.sv - shared widths, master count and FSM state type
package interface_connection;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int N_MASTERS  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/slave_port_arbiter_if.sv
// rtl/slave_port_arbiter_if.sv - master-side and slave-side bus bundle of the arbiter
interface slave_port_arbiter_if #(
  parameter int N  = interface_connection::N_MASTERS,
  parameter int AW = interface_connection::ADDR_WIDTH,
  parameter int DW = interface_connection::DATA_WIDTH
);

  logic [N-1:0]         master_req;
  logic [N-1:0][AW-1:0] master_addr;
  logic [N-1:0]         master_cmd;
  logic [N-1:0][DW-1:0] master_wdata;
  logic [N-1:0]         master_ack;
  logic [N-1:0][DW-1:0] master_rdata;
  logic [N-1:0]         master_resp;

  logic                 slave_req;
  logic                 slave_cmd;
  logic [AW-1:0]        slave_addr;
  logic [DW-1:0]        slave_wdata;
  logic                 slave_ack;
  logic                 slave_resp;
  logic [DW-1:0]        slave_rdata;

  // The arbiter itself sits on the slave modport; requesters and the shared slave on master.
  modport slave (
    input  master_req, master_addr, master_cmd, master_wdata,
    output master_ack, master_rdata, master_resp,
    output slave_req, slave_cmd, slave_addr, slave_wdata,
    input  slave_ack, slave_resp, slave_rdata
  );

  modport master (
    output master_req, master_addr, master_cmd, master_wdata,
    input  master_ack, master_rdata, master_resp,
    input  slave_req, slave_cmd, slave_addr, slave_wdata,
    output slave_ack, slave_resp, slave_rdata
  );

endinterface

// File: rtl/slave_port_arbiter_fifo.sv
// rtl/slave_port_arbiter_fifo.sv - response-ID FIFO recording which master owns each pending read
module resp_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still accept a push in the same cycle it pops.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/slave_port_arbiter.sv
// rtl/slave_port_arbiter.sv - round-robin arbiter sharing one slave port among N masters
module slave_port_arbiter
  import interface_connection::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  slave_port_arbiter_if.slave             bus,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] outstanding
);

  localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             push, pop;
  logic [ID_W-1:0]  head;
  logic [CNT_W-1:0] count;

  // Search upward from the master after the last one served, wrapping around.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last_id_q) + i) % N_MASTERS;
      if (!found && bus.master_req[idx]) begin
        winner = idx[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && (count < CNT_W'(FIFO_DEPTH))) begin
          grant_id_d = winner;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!bus.master_req[grant_id_q]) begin
          state_d = IDLE;
        end else if (bus.slave_ack) begin
          last_id_d = grant_id_q;
          push      = !bus.master_cmd[grant_id_q];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q == GRANT);
    bus.master_ack  = '0;
    bus.slave_req   = 1'b0;
    bus.slave_cmd   = 1'b0;
    bus.slave_addr  = '0;
    bus.slave_wdata = '0;
    if (state_q == GRANT) begin
      bus.master_ack[grant_id_q] = bus.slave_ack;
      bus.slave_req              = bus.master_req[grant_id_q];
      bus.slave_cmd              = bus.master_cmd[grant_id_q];
      bus.slave_addr             = bus.master_addr[grant_id_q];
      bus.slave_wdata            = bus.master_wdata[grant_id_q];
    end
  end

  // Responses arriving with nothing pending are silently dropped.
  always_comb begin
    pop              = bus.slave_resp && (count != '0);
    bus.master_resp  = '0;
    bus.master_rdata = '0;
    if (pop) begin
      bus.master_resp[head]  = 1'b1;
      bus.master_rdata[head] = bus.slave_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_MASTERS-1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

  resp_id_fifo #(
    .WIDTH(ID_W),
    .DEPTH(FIFO_DEPTH)
  ) u_resp_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(grant_id_q),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign outstanding = count;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb/tb_slave_port_arbiter.sv - directed self-checking bench for slave_port_arbiter
module tb_slave_port_arbiter;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] outstanding;
  int         n_cmp;
  int         n_err;

  slave_port_arbiter_if bus ();

  slave_port_arbiter #(
    .N_MASTERS (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.master_req  = '0;
    bus.master_cmd  = '0;
    bus.slave_ack   = 1'b0;
    bus.slave_resp  = 1'b0;
    bus.slave_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction: IDLE cycle then GRANT cycle with slave_ack high.
  task automatic do_xfer(input logic [3:0] req, input logic [3:0] cmd, input int exp_id);
    bus.master_req = req;
    bus.master_cmd = cmd;
    bus.slave_ack  = 1'b1;
    #1;
    check("xfer_idle_busy", 32'(busy), 32'd0);
    tick();
    check("xfer_grant_ack", 32'(bus.master_ack), 32'(1) << exp_id);
    check("xfer_slave_addr", 32'(bus.slave_addr), 32'h10 * (exp_id + 1));
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) begin
      bus.master_addr[i]  = 8'(8'h10 * (i + 1));
      bus.master_wdata[i] = 8'(8'hC0 + i);
    end

    // Reset with every input active: all outputs must stay quiet.
    rst = 1'b1;
    bus.master_req  = 4'b1111;
    bus.master_cmd  = 4'b0000;
    bus.slave_ack   = 1'b1;
    bus.slave_resp  = 1'b1;
    bus.slave_rdata = 8'hFF;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_slave_req", 32'(bus.slave_req), 32'd0);
    check("rst_slave_addr", 32'(bus.slave_addr), 32'd0);
    check("rst_slave_wdata", 32'(bus.slave_wdata), 32'd0);
    check("rst_master_ack", 32'(bus.master_ack), 32'd0);
    check("rst_master_resp", 32'(bus.master_resp), 32'd0);
    check("rst_master_rdata", 32'(bus.master_rdata), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    clear_inputs();
    rst = 1'b0;
    #1;

    // Single read from master 0.
    bus.master_req = 4'b0001;
    #1;
    check("t1_idle_slave_req", 32'(bus.slave_req), 32'd0);
    tick();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_slave_req", 32'(bus.slave_req), 32'd1);
    check("t1_slave_addr", 32'(bus.slave_addr), 32'h10);
    check("t1_slave_cmd", 32'(bus.slave_cmd), 32'd0);
    check("t1_ack_before", 32'(bus.master_ack), 32'd0);
    bus.slave_ack = 1'b1;
    #1;
    check("t1_master_ack", 32'(bus.master_ack), 32'h1);
    tick();
    check("t1_outstanding", 32'(outstanding), 32'd1);
    bus.master_req  = '0;
    bus.slave_ack   = 1'b0;
    bus.slave_resp  = 1'b1;
    bus.slave_rdata = 8'hA5;
    #1;
    check("t1_master_resp", 32'(bus.master_resp), 32'h1);
    check("t1_master_rdata", 32'(bus.master_rdata), 32'h0000_00A5);
    tick();
    bus.slave_resp = 1'b0;
    #1;
    check("t1_drained", 32'(outstanding), 32'd0);

    // Round-robin among four writers.
    do_reset();
    for (int k = 0; k < 5; k++) do_xfer(4'b1111, 4'b1111, k % 4);
    check("t2_write_no_push", 32'(outstanding), 32'd0);

    // FIFO full blocks further grants until a response drains one entry.
    do_reset();
    for (int k = 0; k < 4; k++) do_xfer(4'b1111, 4'b0000, k);
    check("t3_full", 32'(outstanding), 32'd4);
    tick();
    check("t3_starved_busy0", 32'(busy), 32'd0);
    tick();
    check("t3_starved_busy1", 32'(busy), 32'd0);
    check("t3_starved_req", 32'(bus.slave_req), 32'd0);
    bus.slave_resp  = 1'b1;
    bus.slave_rdata = 8'h3C;
    #1;
    check("t3_resp_head", 32'(bus.master_resp), 32'h1);
    check("t3_resp_data", 32'(bus.master_rdata), 32'h0000_003C);
    tick();
    bus.slave_resp = 1'b0;
    #1;
    check("t3_after_pop_busy", 32'(busy), 32'd0);
    check("t3_after_pop_cnt", 32'(outstanding), 32'd3);
    tick();
    check("t3_resume_ack", 32'(bus.master_ack), 32'h1);
    tick();
    check("t3_refull", 32'(outstanding), 32'd4);
    bus.master_req = '0;
    bus.slave_ack  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.slave_resp  = 1'b1;
      bus.slave_rdata = 8'(8'h80 + k);
      #1;
      check("t3_drain_resp", 32'(bus.master_resp), 32'(1) << ((k + 1) % 4));
      check("t3_drain_data", 32'(bus.master_rdata), (32'h80 + k) << (8 * ((k + 1) % 4)));
      tick();
    end
    bus.slave_resp = 1'b0;
    #1;
    check("t3_empty", 32'(outstanding), 32'd0);

    // Response routing follows issue order: master 2 then master 0.
    do_reset();
    do_xfer(4'b0100, 4'b0000, 2);
    do_xfer(4'b0001, 4'b0000, 0);
    bus.master_req  = '0;
    bus.slave_ack   = 1'b0;
    bus.slave_resp  = 1'b1;
    bus.slave_rdata = 8'h11;
    #1;
    check("t4_resp_m2", 32'(bus.master_resp), 32'h4);
    check("t4_data_m2", 32'(bus.master_rdata), 32'h0011_0000);
    tick();
    bus.slave_rdata = 8'h22;
    #1;
    check("t4_resp_m0", 32'(bus.master_resp), 32'h1);
    check("t4_data_m0", 32'(bus.master_rdata), 32'h0000_0022);
    tick();
    bus.slave_resp = 1'b0;

    // Write gets no response; stray slave_resp is dropped.
    do_xfer(4'b0010, 4'b0010, 1);
    check("t5_write_cnt", 32'(outstanding), 32'd0);
    bus.master_req  = '0;
    bus.slave_ack   = 1'b0;
    bus.slave_resp  = 1'b1;
    bus.slave_rdata = 8'h55;
    #1;
    check("t5_stray_resp", 32'(bus.master_resp), 32'd0);
    check("t5_stray_data", 32'(bus.master_rdata), 32'd0);
    tick();
    bus.slave_resp = 1'b0;
    #1;
    check("t5_stray_cnt", 32'(outstanding), 32'd0);

    // Request withdrawn in GRANT: back to IDLE, no push, last_id kept at 1.
    bus.master_req = 4'b1000;
    bus.master_cmd = 4'b0000;
    #1;
    tick();
    check("t5_drop_busy", 32'(busy), 32'd1);
    bus.master_req = '0;
    #1;
    tick();
    check("t5_drop_idle", 32'(busy), 32'd0);
    check("t5_drop_cnt", 32'(outstanding), 32'd0);
    do_xfer(4'b1111, 4'b1111, 2);

    // Reset in GRANT with two reads pending.
    do_reset();
    do_xfer(4'b0011, 4'b0000, 0);
    do_xfer(4'b0011, 4'b0000, 1);
    check("t6_pending", 32'(outstanding), 32'd2);
    bus.master_req = 4'b0100;
    bus.slave_ack  = 1'b0;
    #1;
    tick();
    check("t6_in_grant", 32'(busy), 32'd1);
    check("t6_in_grant_req", 32'(bus.slave_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cnt", 32'(outstanding), 32'd0);
    check("t6_rst_req", 32'(bus.slave_req), 32'd0);
    tick();
    check("t6_rst_busy_edge", 32'(busy), 32'd0);
    check("t6_rst_cnt_edge", 32'(outstanding), 32'd0);
    rst = 1'b0;
    bus.master_req = '0;
    bus.slave_resp = 1'b1;
    #1;
    check("t6_ids_discarded", 32'(bus.master_resp), 32'd0);
    tick();
    bus.slave_resp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 SHALL take parameter N_MASTERS, default 4, number of requesting masters.
REQ-003 SHALL take parameter FIFO_DEPTH, default 4, maximum number of outstanding reads.
REQ-004 master_req  input  N_MASTERS  per-master request.
REQ-005 master_addr  input  N_MASTERS x ADDR_WIDTH  per-master address.
REQ-006 master_cmd  input  N_MASTERS  per-master command (0 = read, 1 = write).
REQ-007 master_wdata  input  N_MASTERS x DATA_WIDTH  per-master write data.
REQ-008 master_ack  output  N_MASTERS  per-master request accepted.
REQ-009 master_rdata  output  N_MASTERS x DATA_WIDTH  per-master read data.
REQ-010 master_resp  output  N_MASTERS  per-master read response valid.
REQ-011 slave_req, slave_cmd  output  1 each; slave_addr  output  ADDR_WIDTH; slave_wdata  output  DATA_WIDTH  request to the shared slave.
REQ-012 slave_ack  input  1; slave_resp  input  1; slave_rdata  input  DATA_WIDTH  slave acceptance and read return.
REQ-013 busy  output  1  high while the FSM is in GRANT; outstanding  output  clog2(FIFO_DEPTH+1)  count of reads awaiting response.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE and GRANT.
REQ-015 In IDLE, if any master_req is high and outstanding < FIFO_DEPTH, the FSM SHALL register the winner index in grant_id and move to GRANT on the next edge.
REQ-016 The winner SHALL be chosen round-robin: the first requester searching upward (with wrap) from last_id+1.
REQ-017 In IDLE with outstanding == FIFO_DEPTH, no grant SHALL be issued, regardless of the requested cmd.
REQ-018 In GRANT, the slave request signals (slave_req/addr/cmd/wdata) SHALL combinationally follow the request signals of master grant_id; in IDLE, slave_req SHALL be 0.
REQ-019 In GRANT, master_ack[grant_id] SHALL equal slave_ack in the same cycle; all other master_ack bits SHALL be 0.
REQ-020 On a GRANT cycle with slave_ack high: last_id <= grant_id; if cmd = 0, grant_id is pushed into the response-ID FIFO; next state is IDLE.
REQ-021 Consequence of REQ-015 and REQ-020: minimum request-to-slave_req latency is 1 cycle, and back-to-back transactions occupy 2 cycles each.
REQ-022 If master_req[grant_id] drops in GRANT without slave_ack, the FSM SHALL return to IDLE with no FIFO push and no last_id update.
REQ-023 When slave_resp is high and the FIFO is non-empty: master_resp[head] = 1 and master_rdata[head] = slave_rdata in the same cycle, and the FIFO pops.
REQ-024 master_rdata of non-selected masters SHALL be 0; master_resp SHALL be all 0 when slave_resp is low.
REQ-025 slave_resp with an empty FIFO SHALL be dropped: no master_resp asserted and no state change.
REQ-026 A simultaneous push and pop SHALL leave outstanding unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Writes SHALL never be pushed into the FIFO and SHALL receive no routed response.

Reset
REQ-028 On rst: state = IDLE, grant_id = 0, last_id = N_MASTERS-1 (so master 0 has first priority), FIFO empty, outstanding = 0.
REQ-029 During reset, all master_ack, master_resp, master_rdata, slave_req and busy SHALL be 0; slave_addr, slave_cmd and slave_wdata SHALL be 0.
REQ-030 Reset asserted in GRANT SHALL abort the transaction and discard all pending read IDs.

Structure
REQ-031 ADDR_WIDTH, DATA_WIDTH, N_MASTERS and the FSM state enum (IDLE, GRANT) SHALL reside in package interface_connection.
REQ-032 The response-ID FIFO SHALL be a sub-module, resp_id_fifo (parameters WIDTH and DEPTH; push, pop, head, count).

Verification
REQ-033 Reset, then master_req = 4'b0001 with read to addr 0x10 -> slave_req 1 cycle later with addr 0x10; slave_ack -> master_ack[0]; slave_resp with rdata 0xA5 -> master_resp[0] and master_rdata[0] = 0xA5.
REQ-034 master_req = 4'b1111 held, slave_ack every GRANT cycle -> grant order 0,1,2,3,0.
REQ-035 Four reads acked with no slave_resp -> outstanding = 4, fifth request is not granted; one slave_resp -> grant resumes.
REQ-036 Masters 2 then 0 issue reads, then two slave_resp pulses with rdata 0x11, 0x22 -> master 2 receives 0x11, master 0 receives 0x22.
REQ-037 Write from master 1 acked, then slave_resp with FIFO empty -> no master_resp asserted, outstanding stays 0.
REQ-038 rst asserted in GRANT with 2 reads outstanding -> next cycle state = IDLE, outstanding = 0, slave_req = 0.
